hssi_rst_seq: RTL

- Sits directly downstream of the HSSI wrapper CSR block.
- Consumes its level-type reset requests (cold, per-channel TX/RX) and runs the req/ack handshake with the HSSI subsystem's active-low reset ports.
- Drives per-channel AXI-S resets for the whole handshake window.
- Returns handshake-complete acks and sticky timeout errors to the CSR block for software visibility.

---
 rtl/hssi_rst_seq_pkg.sv | 23 ++
 rtl/hssi_rst_hs_unit.sv | 103 ++++++++++
 rtl/hssi_rst_seq.sv | 95 +++++++++
 3 files changed

// File: rtl/hssi_rst_seq_pkg.sv
// Shared types and sizing helpers for the HSSI reset sequencer.
// One handshake FSM per cold/TX/RX reset domain.
package hssi_rst_seq_pkg;

  localparam int MAX_NUM_ETH_CHANNELS = 16;
  localparam int NUM_UNITS = 2 * MAX_NUM_ETH_CHANNELS + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_HELD,
    ST_RELEASE
  } hs_st_e;

  function automatic int tmr_w(input int cyc);
    return $clog2(cyc + 1);
  endfunction

  function automatic int num_units(input int nch);
    return 2 * nch + 1;
  endfunction

endpackage

// File: rtl/hssi_rst_hs_unit.sv
// One req/ack reset handshake with the SS: ack synchronizer,
// phase timer and sticky timeout flag.
module hssi_rst_hs_unit
  import hssi_rst_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = 65535,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_ack_n,
  input  logic i_err_clr,
  output logic o_rst_n,
  output logic o_ack,
  output logic o_to,
  output logic o_busy
);

  localparam int TW = tmr_w(TIMEOUT_CYC);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  hs_st_e                 r_st;
  logic [TW-1:0]          r_tmr;
  logic                   r_rst_n;
  logic                   r_ack;
  logic                   r_to;

  logic          w_sack;
  logic          w_tmr_max;
  logic [TW-1:0] w_tmr_inc;
  logic          w_set_to;

  assign w_sack    = ~r_sync[SYNC_STAGES-1];
  assign w_tmr_max = (r_tmr == TLAST);
  assign w_tmr_inc = (&r_tmr) ? r_tmr : r_tmr + 1'b1;
  assign w_set_to  = w_tmr_max &
                     (((r_st == ST_ASSERT) & ~w_sack) |
                      ((r_st == ST_RELEASE) & w_sack));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_ack_n};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st    <= ST_IDLE;
      r_tmr   <= '0;
      r_rst_n <= 1'b1;
      r_ack   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      unique case (r_st)
        ST_IDLE: begin
          r_tmr <= '0;
          if (i_req) begin
            r_st    <= ST_ASSERT;
            r_rst_n <= 1'b0;
          end
        end
        ST_ASSERT: begin
          r_tmr <= w_tmr_inc;
          if (w_sack || w_tmr_max) begin
            r_st  <= ST_HELD;
            r_ack <= 1'b1;
          end
        end
        ST_HELD: begin
          if (!i_req) begin
            r_st    <= ST_RELEASE;
            r_rst_n <= 1'b1;
            r_tmr   <= '0;
          end
        end
        ST_RELEASE: begin
          r_tmr <= w_tmr_inc;
          if (!w_sack || w_tmr_max) begin
            r_st  <= ST_IDLE;
            r_ack <= 1'b0;
          end
        end
        default: r_st <= ST_IDLE;
      endcase
      // a timeout in the same cycle as a clear must stay visible
      if (w_set_to) begin
        r_to <= 1'b1;
      end else if (i_err_clr) begin
        r_to <= 1'b0;
      end
    end
  end

  assign o_rst_n = r_rst_n;
  assign o_ack   = r_ack;
  assign o_to    = r_to;
  assign o_busy  = (r_st != ST_IDLE);

endmodule

// File: rtl/hssi_rst_seq.sv
// HSSI reset sequencer: cold + per-lane TX/RX handshakes with the
// SS reset ports, cold override and AXI-S reset generation.
module hssi_rst_seq
  import hssi_rst_seq_pkg::*;
#(
  parameter int NUM_CH      = MAX_NUM_ETH_CHANNELS,
  parameter int TIMEOUT_CYC = 65535,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cold_rst,
  input  logic [NUM_CH-1:0] i_tx_rst,
  input  logic [NUM_CH-1:0] i_rx_rst,
  input  logic              i_err_clr,
  output logic              o_ss_cold_rst_n,
  input  logic              i_ss_cold_rst_ack_n,
  output logic [NUM_CH-1:0] o_ss_tx_rst_n,
  input  logic [NUM_CH-1:0] i_ss_tx_rst_ack_n,
  output logic [NUM_CH-1:0] o_ss_rx_rst_n,
  input  logic [NUM_CH-1:0] i_ss_rx_rst_ack_n,
  output logic              o_cold_rst_ack,
  output logic [NUM_CH-1:0] o_tx_rst_ack,
  output logic [NUM_CH-1:0] o_rx_rst_ack,
  output logic [NUM_CH-1:0] o_axis_tx_areset,
  output logic [NUM_CH-1:0] o_axis_rx_areset,
  output logic              o_cold_rst_to,
  output logic [NUM_CH-1:0] o_tx_rst_to,
  output logic [NUM_CH-1:0] o_rx_rst_to
);

  localparam int NU = num_units(NUM_CH);

  logic [NU-1:0]     w_req;
  logic [NU-1:0]     w_ack_n;
  logic [NU-1:0]     w_rst_n;
  logic [NU-1:0]     w_ack;
  logic [NU-1:0]     w_to;
  logic [NU-1:0]     w_busy;
  logic              w_cold_busy;
  logic [NUM_CH-1:0] w_cold_vec;
  logic [NUM_CH-1:0] r_tx_areset;
  logic [NUM_CH-1:0] r_rx_areset;

  assign w_cold_busy = w_busy[0];
  assign w_cold_vec  = {NUM_CH{w_cold_busy}};

  // unit 0 is cold, then TX lanes, then RX lanes
  assign w_req = {i_rx_rst | w_cold_vec,
                  i_tx_rst | w_cold_vec,
                  i_cold_rst};
  assign w_ack_n = {i_ss_rx_rst_ack_n,
                    i_ss_tx_rst_ack_n,
                    i_ss_cold_rst_ack_n};

  for (genvar gi = 0; gi < NU; gi++) begin : g_unit
    hssi_rst_hs_unit #(
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_hs (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req    (w_req[gi]),
      .i_ack_n  (w_ack_n[gi]),
      .i_err_clr(i_err_clr),
      .o_rst_n  (w_rst_n[gi]),
      .o_ack    (w_ack[gi]),
      .o_to     (w_to[gi]),
      .o_busy   (w_busy[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_areset <= '0;
      r_rx_areset <= '0;
    end else begin
      r_tx_areset <= w_busy[NUM_CH:1] | i_tx_rst | w_cold_vec;
      r_rx_areset <= w_busy[2*NUM_CH:NUM_CH+1] | i_rx_rst | w_cold_vec;
    end
  end

  assign o_ss_cold_rst_n  = w_rst_n[0];
  assign o_ss_tx_rst_n    = w_rst_n[NUM_CH:1];
  assign o_ss_rx_rst_n    = w_rst_n[2*NUM_CH:NUM_CH+1];
  assign o_cold_rst_ack   = w_ack[0];
  assign o_tx_rst_ack     = w_ack[NUM_CH:1];
  assign o_rx_rst_ack     = w_ack[2*NUM_CH:NUM_CH+1];
  assign o_cold_rst_to    = w_to[0];
  assign o_tx_rst_to      = w_to[NUM_CH:1];
  assign o_rx_rst_to      = w_to[2*NUM_CH:NUM_CH+1];
  assign o_axis_tx_areset = r_tx_areset;
  assign o_axis_rx_areset = r_rx_areset;

endmodule
